arbitro_unidade_logica: RTL and testbench

Arbitrates a single shared bitwise logic unit (AND/OR/XOR/NAND) among NUM_REQ requesters in the processor datapath. Each requester raises a request with its operands and opcode. The block grants one requester, latches its operands, computes the result in a registered stage and returns it tagged with the requester index. It is the controller that sequences and time-shares the gate-level logic unit (PortaAND and siblings).

---
 rtl/arbitro_unidade_logica_pkg.sv | 21 ++
 rtl/arbitro_unidade_logica_unidade_logica.sv | 26 ++
 rtl/arbitro_unidade_logica.sv | 135 +++++++++++++
 tb/tb_arbitro_unidade_logica.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/arbitro_unidade_logica_pkg.sv
// Shared types and default sizes for the logic-unit arbiter and its
// shared bitwise unit.
package pacote_unidade_logica;

  localparam int NUM_REQ_PADRAO = 4;
  localparam int LARGURA_PADRAO = 8;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    EXECUTA = 2'b01,
    ENTREGA = 2'b10
  } estado_t;

endpackage

// File: rtl/arbitro_unidade_logica_unidade_logica.sv
// Combinational bitwise logic unit (AND/OR/XOR/NAND). One instance is the
// resource that the arbiter time-shares between requesters.
module unidade_logica
  import pacote_unidade_logica::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  input  opcode_t            Op,
  output logic [LARGURA-1:0] Y
);

  // Pure bitwise operation selected by the opcode; no carry chain.
  always_comb begin
    Y = '0;
    case (Op)
      OP_AND:  Y = A & B;
      OP_OR:   Y = A | B;
      OP_XOR:  Y = A ^ B;
      OP_NAND: Y = ~(A & B);
      default: Y = '0;
    endcase
  end

endmodule

// File: rtl/arbitro_unidade_logica.sv
// Arbiter/sequencer for the shared bitwise logic unit. Grants one requester,
// latches its operands, registers the unit output and returns it tagged with
// the requester index.
// Build option: ARBITRO_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest requesting index always wins.
module arbitro_unidade_logica
  import pacote_unidade_logica::*;
#(
  parameter  int NUM_REQ = NUM_REQ_PADRAO,
  parameter  int LARGURA = LARGURA_PADRAO,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [NUM_REQ*LARGURA-1:0] Operando1,
  input  logic [NUM_REQ*LARGURA-1:0] Operando2,
  input  logic [NUM_REQ*2-1:0]       Operacao,
  output logic [NUM_REQ-1:0]         Grant,
  output logic [LARGURA-1:0]         Resultado,
  output logic                       ResultadoValido,
  output logic [ID_W-1:0]            ResultadoId,
  output logic                       Ocupado
);

  estado_t              estado;
  logic [ID_W-1:0]      vencedor;
  logic                 achou;
  logic                 aceita;
  logic [NUM_REQ-1:0]   grant_novo;
  logic [LARGURA-1:0]   op_a;
  logic [LARGURA-1:0]   op_b;
  opcode_t              op_sel;
  logic [ID_W-1:0]      id_lat;
  logic [LARGURA-1:0]   y;

`ifdef ARBITRO_ROUND_ROBIN_EN
  logic [ID_W-1:0]      ponteiro;
  int                   idx_busca;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    vencedor  = '0;
    achou     = 1'b0;
    idx_busca = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_busca = (int'(ponteiro) + k) % NUM_REQ;
      if (!achou && Req[idx_busca]) begin
        achou    = 1'b1;
        vencedor = ID_W'(idx_busca);
      end
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    vencedor = '0;
    achou    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!achou && Req[k]) begin
        achou    = 1'b1;
        vencedor = ID_W'(k);
      end
    end
  end
`endif

  // Requests are only sampled in OCIOSO and ENTREGA; EXECUTA ignores them.
  assign aceita     = ((estado == OCIOSO) || (estado == ENTREGA)) && (|Req);
  assign grant_novo = NUM_REQ'(1) << vencedor;

  unidade_logica #(
    .LARGURA (LARGURA)
  ) u_unidade_logica (
    .A  (op_a),
    .B  (op_b),
    .Op (op_sel),
    .Y  (y)
  );

  // Operand latch: captures the winner's slices on the accepting edge only.
  always_ff @(posedge Clock) begin
    if (aceita) begin
      op_a   <= Operando1[vencedor*LARGURA +: LARGURA];
      op_b   <= Operando2[vencedor*LARGURA +: LARGURA];
      op_sel <= opcode_t'(Operacao[vencedor*2 +: 2]);
      id_lat <= vencedor;
    end
  end

  // Sequencing FSM with registered Grant/result/status outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado          <= OCIOSO;
      Grant           <= '0;
      Resultado       <= '0;
      ResultadoValido <= 1'b0;
      ResultadoId     <= '0;
      Ocupado         <= 1'b0;
`ifdef ARBITRO_ROUND_ROBIN_EN
      ponteiro        <= '0;
`endif
    end else begin
      Grant           <= '0;
      ResultadoValido <= 1'b0;
      case (estado)
        OCIOSO, ENTREGA: begin
          if (aceita) begin
            Grant   <= grant_novo;
            estado  <= EXECUTA;
            Ocupado <= 1'b1;
`ifdef ARBITRO_ROUND_ROBIN_EN
            ponteiro <= (vencedor == ID_W'(NUM_REQ - 1)) ? '0 : vencedor + 1'b1;
`endif
          end else begin
            estado  <= OCIOSO;
            Ocupado <= 1'b0;
          end
        end
        EXECUTA: begin
          Resultado       <= y;
          ResultadoValido <= 1'b1;
          ResultadoId     <= id_lat;
          estado          <= ENTREGA;
          Ocupado         <= 1'b1;
        end
        default: begin
          estado  <= OCIOSO;
          Ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_unidade_logica.sv
// Directed self-checking bench for arbitro_unidade_logica (NUM_REQ=4,
// LARGURA=8). Inputs change on the falling edge; outputs are checked on
// the falling edge or just after an asynchronous reset.
module tb_arbitro_unidade_logica;

  logic        Clock;
  logic        Reset;
  logic [3:0]  Req;
  logic [31:0] Operando1;
  logic [31:0] Operando2;
  logic [7:0]  Operacao;
  logic [3:0]  Grant;
  logic [7:0]  Resultado;
  logic        ResultadoValido;
  logic [1:0]  ResultadoId;
  logic        Ocupado;

  int checks   = 0;
  int failures = 0;

  arbitro_unidade_logica #(
    .NUM_REQ (4),
    .LARGURA (8)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Req             (Req),
    .Operando1       (Operando1),
    .Operando2       (Operando2),
    .Operacao        (Operacao),
    .Grant           (Grant),
    .Resultado       (Resultado),
    .ResultadoValido (ResultadoValido),
    .ResultadoId     (ResultadoId),
    .Ocupado         (Ocupado)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op);
    Operando1[idx*8 +: 8] = a;
    Operando2[idx*8 +: 8] = b;
    Operacao[idx*2 +: 2]  = op;
  endtask

  // One isolated transaction from idle, checked through its whole life.
  task automatic send(input string tag, input int idx, input logic [7:0] a,
                      input logic [7:0] b, input logic [1:0] op,
                      input logic [7:0] exp);
    set_op(idx, a, b, op);
    Req = 4'b0001 << idx;
    @(negedge Clock);
    chk({tag, "_grant"}, Grant, 32'(4'b0001 << idx));
    chk({tag, "_busy"}, Ocupado, 1);
    Req = 4'b0000;
    @(negedge Clock);
    chk({tag, "_grant_off"}, Grant, 0);
    chk({tag, "_valid"}, ResultadoValido, 1);
    chk({tag, "_result"}, Resultado, exp);
    chk({tag, "_id"}, ResultadoId, idx);
    @(negedge Clock);
    chk({tag, "_valid_off"}, ResultadoValido, 0);
    chk({tag, "_idle"}, Ocupado, 0);
    chk({tag, "_hold"}, Resultado, exp);
  endtask

  logic [3:0] exp_grant [5];
  logic [1:0] exp_id    [5];
  logic [7:0] exp_res   [5];

  initial begin
`ifdef ARBITRO_ROUND_ROBIN_EN
    exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_res   = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hFF};
`else
    exp_grant = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_id    = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_res   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
    Reset     = 1'b1;
    Req       = '0;
    Operando1 = '0;
    Operando2 = '0;
    Operacao  = '0;

    // Reset state
    @(negedge Clock);
    chk("rst_grant", Grant, 0);
    chk("rst_valid", ResultadoValido, 0);
    chk("rst_result", Resultado, 0);
    chk("rst_id", ResultadoId, 0);
    chk("rst_busy", Ocupado, 0);
    Reset = 1'b0;
    @(negedge Clock);

    // Single request, AND on requester 0
    send("and_r0", 0, 8'hF0, 8'h3C, 2'b00, 8'h30);

    // Opcode coverage on requester 2
    send("xor_r2", 2, 8'hAA, 8'hFF, 2'b10, 8'h55);
    send("or_r2", 2, 8'h0F, 8'hF0, 2'b01, 8'hFF);
    send("nand_r2", 2, 8'hFF, 8'h0F, 2'b11, 8'hF0);

    // Mid-cycle reset while all four request and one is granted
    for (int i = 0; i < 4; i++) set_op(i, 8'(i * 8'h11), 8'hFF, 2'b11);
    Req = 4'b1111;
    @(negedge Clock);
    chk("pre_rst_busy", Ocupado, 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_grant", Grant, 0);
    chk("async_rst_valid", ResultadoValido, 0);
    chk("async_rst_result", Resultado, 0);
    chk("async_rst_id", ResultadoId, 0);
    chk("async_rst_busy", Ocupado, 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Contention with Req=1111 held: one grant every two cycles
    for (int n = 0; n < 5; n++) begin
      @(negedge Clock);
      chk($sformatf("cont%0d_grant", n), Grant, exp_grant[n]);
      chk($sformatf("cont%0d_nvalid", n), ResultadoValido, 0);
      @(negedge Clock);
      chk($sformatf("cont%0d_valid", n), ResultadoValido, 1);
      chk($sformatf("cont%0d_id", n), ResultadoId, exp_id[n]);
      chk($sformatf("cont%0d_result", n), Resultado, exp_res[n]);
      chk($sformatf("cont%0d_busy", n), Ocupado, 1);
      if (n == 4) Req = 4'b0000;
    end
    @(negedge Clock);
    chk("cont_end_idle", Ocupado, 0);
    chk("cont_end_grant", Grant, 0);

    // Back-to-back: requester 1, then requester 3 arriving during EXECUTA
    set_op(1, 8'h12, 8'h21, 2'b01);
    set_op(3, 8'hFF, 8'h5A, 2'b00);
    Req = 4'b0010;
    @(negedge Clock);
    chk("b2b_grant1", Grant, 4'b0010);
    Req = 4'b1000;
    @(negedge Clock);
    chk("b2b_valid1", ResultadoValido, 1);
    chk("b2b_id1", ResultadoId, 1);
    chk("b2b_result1", Resultado, 8'h33);
    chk("b2b_busy1", Ocupado, 1);
    chk("b2b_nogrant", Grant, 0);
    @(negedge Clock);
    chk("b2b_grant3", Grant, 4'b1000);
    chk("b2b_gap_valid", ResultadoValido, 0);
    chk("b2b_busy2", Ocupado, 1);
    Req = 4'b0000;
    @(negedge Clock);
    chk("b2b_valid3", ResultadoValido, 1);
    chk("b2b_id3", ResultadoId, 3);
    chk("b2b_result3", Resultado, 8'h5A);
    chk("b2b_busy3", Ocupado, 1);
    @(negedge Clock);
    chk("b2b_idle", Ocupado, 0);

    // Reset while in EXECUTA discards the operation
    set_op(0, 8'h0F, 8'h0F, 2'b10);
    Req = 4'b0001;
    @(negedge Clock);
    chk("abort_grant", Grant, 4'b0001);
    Req = 4'b0000;
    Reset = 1'b1;
    #1;
    chk("abort_busy", Ocupado, 0);
    @(negedge Clock);
    chk("abort_novalid", ResultadoValido, 0);
    Reset = 1'b0;
    @(negedge Clock);
    chk("abort_novalid2", ResultadoValido, 0);
    chk("abort_idle", Ocupado, 0);
    send("after_abort", 1, 8'h3C, 8'hC3, 2'b01, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
